// File: rtl/cdc_pkg.sv
// Shared types and helpers for the multi-channel request/acknowledge receiver.
package cdc_pkg;

  // Per-channel handshake state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKH = 2'd2
  } chan_state_t;

  // Width of a channel index; never narrower than one bit so a
  // single-channel build still has a legal m_chan port.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_mchan_rx_chan.sv
// One receive channel: request synchroniser, handshake FSM, hold register
// and acknowledge flop. Raises pend while waiting for the arbiter.
module cdc_mchan_rx_chan
  import cdc_pkg::*;
#(
  parameter int NUM_CDC_STAGE = 2,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 req_async,
  input  logic [BUS_WIDTH-1:0] bus_async,
  input  logic                 grant,
  output logic                 pend,
  output logic [BUS_WIDTH-1:0] hold_data,
  output logic                 ack,
  output logic                 busy
);

  (* ASYNC_REG = "TRUE" *) logic [NUM_CDC_STAGE-1:0] sync;
  logic        req_s;
  chan_state_t state;

  assign req_s = sync[NUM_CDC_STAGE-1];
  assign pend  = (state == PEND);
  assign busy  = (state != IDLE);

  // Request synchroniser chain into aclk.
  always_ff @(posedge aclk) begin
    if (srst) begin
      sync <= '0;
    end else begin
      sync <= {sync[NUM_CDC_STAGE-2:0], req_async};
    end
  end

  // Handshake FSM. The bus capture in IDLE is a multicycle path: the sender
  // holds bus_async stable well before req_s rises, so it is constrained with
  // a max-delay exception rather than cut as a false path. ack is a plain
  // flop that rises only together with the grant, i.e. in the same cycle the
  // word enters the output register.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state     <= IDLE;
      hold_data <= '0;
      ack       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            hold_data <= bus_async;
            state     <= PEND;
          end
        end
        PEND: begin
          if (grant) begin
            state <= ACKH;
            ack   <= 1'b1;
          end
        end
        ACKH: begin
          if (!req_s) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cdc_mchan_rx.sv
// Multi-channel four-phase receive crossing: per-channel synchronise/capture,
// round-robin merge onto one valid/ready stream tagged with the channel index.
module cdc_mchan_rx
  import cdc_pkg::*;
#(
  parameter int  NUM_CDC_STAGE = 2,
  parameter int  NUM_CHANNELS  = 4,
  parameter int  BUS_WIDTH     = 32,
  localparam int CHAN_W        = chan_w(NUM_CHANNELS)
) (
  input  logic                              aclk,
  input  logic                              srst,
  input  logic [NUM_CHANNELS-1:0]           req_async,
  input  logic [NUM_CHANNELS*BUS_WIDTH-1:0] bus_async,
  output logic [NUM_CHANNELS-1:0]           ack_async,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [BUS_WIDTH-1:0]              m_data,
  output logic [CHAN_W-1:0]                 m_chan,
  output logic                              busy
);

  logic [NUM_CHANNELS-1:0]                pend;
  logic [NUM_CHANNELS-1:0]                grant;
  logic [NUM_CHANNELS-1:0]                chan_busy;
  logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0] hold;
  logic [CHAN_W-1:0]                      last_grant;
  logic [CHAN_W-1:0]                      gnt_idx;
  logic [CHAN_W-1:0]                      cand;
  logic                                   gnt_any;
  logic                                   out_free;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    cdc_mchan_rx_chan #(
      .NUM_CDC_STAGE(NUM_CDC_STAGE),
      .BUS_WIDTH    (BUS_WIDTH)
    ) u_chan (
      .aclk     (aclk),
      .srst     (srst),
      .req_async(req_async[g]),
      .bus_async(bus_async[g*BUS_WIDTH +: BUS_WIDTH]),
      .grant    (grant[g]),
      .pend     (pend[g]),
      .hold_data(hold[g]),
      .ack      (ack_async[g]),
      .busy     (chan_busy[g])
    );
  end

  assign busy     = |chan_busy;
  assign out_free = !m_valid || m_ready;

  // Round-robin arbiter: first pending channel after last_grant, wrapping.
  // Only runs when the output register can accept a word.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (out_free) begin
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
        cand = CHAN_W'((int'(last_grant) + i) % NUM_CHANNELS);
        if (!gnt_any && pend[cand]) begin
          gnt_any     = 1'b1;
          gnt_idx     = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  // Output register and round-robin pointer; a grant reloads the register in
  // the same cycle as a handshake so back-to-back beats are possible.
  always_ff @(posedge aclk) begin
    if (srst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_chan     <= '0;
      last_grant <= CHAN_W'(NUM_CHANNELS - 1);
    end else if (gnt_any) begin
      m_valid    <= 1'b1;
      m_data     <= hold[gnt_idx];
      m_chan     <= gnt_idx;
      last_grant <= gnt_idx;
    end else if (m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_mchan_rx.sv
// Directed bench for cdc_mchan_rx (2 sync stages, 4 channels, 32-bit data).
module tb_cdc_mchan_rx;

  logic         aclk;
  logic         srst;
  logic [3:0]   req_async;
  logic [127:0] bus_async;
  logic [3:0]   ack_async;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic [1:0]   m_chan;
  logic         busy;

  int n_tests;
  int n_fail;

  cdc_mchan_rx #(
    .NUM_CDC_STAGE(2),
    .NUM_CHANNELS (4),
    .BUS_WIDTH    (32)
  ) dut (
    .aclk     (aclk),
    .srst     (srst),
    .req_async(req_async),
    .bus_async(bus_async),
    .ack_async(ack_async),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .busy     (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic         rdy;
    logic [127:0] bus;
    logic         vld;
    logic [31:0]  dat;
    logic [1:0]   ch;
    logic [3:0]   ack;
    logic         bsy;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl[NV];

  localparam logic [127:0] BA0 = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
  localparam logic [127:0] BA1 = {32'h0, 32'h0, 32'h12345678, 32'h0};
  localparam logic [127:0] BB  = {32'h13, 32'h12, 32'h11, 32'h10};
  localparam logic [127:0] BC0 = {32'h0, 32'h22, 32'h0, 32'h0};
  localparam logic [127:0] BC1 = {32'h33, 32'h22, 32'h31, 32'h0};

  function automatic vec_t v(logic rst, logic [3:0] req, logic rdy, logic [127:0] bus,
                             logic vld, logic [31:0] dat, logic [1:0] ch,
                             logic [3:0] ack, logic bsy);
    vec_t r;
    r.rst = rst; r.req = req; r.rdy = rdy; r.bus = bus;
    r.vld = vld; r.dat = dat; r.ch = ch; r.ack = ack; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic vld, input logic [31:0] dat,
                         input logic [1:0] ch, input logic [3:0] ack, input logic bsy,
                         input logic chk_dat);
    chk({tag, " m_valid"}, 32'(m_valid), 32'(vld));
    chk({tag, " ack"}, 32'(ack_async), 32'(ack));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
    if (chk_dat) begin
      chk({tag, " m_data"}, m_data, dat);
      chk({tag, " m_chan"}, 32'(m_chan), 32'(ch));
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    srst      = 1'b1;
    req_async = '0;
    bus_async = '0;
    m_ready   = 1'b1;

    // Single transfer on ch1, data changed by sender after ack, held under back-pressure.
    tbl[0]  = v(1, 4'b0000, 1, 128'h0, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[1]  = v(0, 4'b0010, 1, BA0, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[2]  = v(0, 4'b0010, 1, BA0, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[3]  = v(0, 4'b0010, 1, BA0, 0, 32'h0, 2'd0, 4'b0000, 1);
    tbl[4]  = v(0, 4'b0010, 1, BA0, 1, 32'hDEADBEEF, 2'd1, 4'b0010, 1);
    tbl[5]  = v(0, 4'b0000, 0, BA1, 1, 32'hDEADBEEF, 2'd1, 4'b0010, 1);
    tbl[6]  = v(0, 4'b0000, 1, BA1, 0, 32'h0, 2'd0, 4'b0010, 1);
    tbl[7]  = v(0, 4'b0000, 1, BA1, 0, 32'h0, 2'd0, 4'b0000, 0);
    // All four channels request together after reset: beats 0,1,2,3.
    tbl[8]  = v(1, 4'b0000, 1, BA1, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[9]  = v(0, 4'b1111, 1, BB, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[10] = v(0, 4'b1111, 1, BB, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[11] = v(0, 4'b1111, 1, BB, 0, 32'h0, 2'd0, 4'b0000, 1);
    tbl[12] = v(0, 4'b1111, 1, BB, 1, 32'h10, 2'd0, 4'b0001, 1);
    tbl[13] = v(0, 4'b1111, 1, BB, 1, 32'h11, 2'd1, 4'b0011, 1);
    tbl[14] = v(0, 4'b1111, 1, BB, 1, 32'h12, 2'd2, 4'b0111, 1);
    tbl[15] = v(0, 4'b1111, 1, BB, 1, 32'h13, 2'd3, 4'b1111, 1);
    tbl[16] = v(0, 4'b0000, 1, BB, 0, 32'h0, 2'd0, 4'b1111, 1);
    tbl[17] = v(0, 4'b0000, 1, BB, 0, 32'h0, 2'd0, 4'b1111, 1);
    tbl[18] = v(0, 4'b0000, 1, BB, 0, 32'h0, 2'd0, 4'b0000, 0);
    // ch2 granted last, then ch1 and ch3 pending together: order 3 then 1.
    tbl[19] = v(0, 4'b0100, 1, BC0, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[20] = v(0, 4'b0100, 1, BC0, 0, 32'h0, 2'd0, 4'b0000, 0);
    tbl[21] = v(0, 4'b1110, 1, BC1, 0, 32'h0, 2'd0, 4'b0000, 1);
    tbl[22] = v(0, 4'b1110, 1, BC1, 1, 32'h22, 2'd2, 4'b0100, 1);
    tbl[23] = v(0, 4'b1010, 1, BC1, 0, 32'h0, 2'd0, 4'b0100, 1);
    tbl[24] = v(0, 4'b1010, 1, BC1, 1, 32'h33, 2'd3, 4'b1100, 1);
    tbl[25] = v(0, 4'b1010, 1, BC1, 1, 32'h31, 2'd1, 4'b1010, 1);
    tbl[26] = v(0, 4'b0000, 1, BC1, 0, 32'h0, 2'd0, 4'b1010, 1);
    tbl[27] = v(0, 4'b0000, 1, BC1, 0, 32'h0, 2'd0, 4'b1010, 1);
    tbl[28] = v(0, 4'b0000, 1, BC1, 0, 32'h0, 2'd0, 4'b0000, 0);

    for (int i = 0; i < NV; i++) begin
      srst      = tbl[i].rst;
      req_async = tbl[i].req;
      m_ready   = tbl[i].rdy;
      bus_async = tbl[i].bus;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].vld, tbl[i].dat, tbl[i].ch, tbl[i].ack,
              tbl[i].bsy, tbl[i].vld || tbl[i].rst);
    end

    // Back-pressure: ch0 and ch2 pending, m_ready low for 10 cycles.
    srst = 1'b1; req_async = '0; m_ready = 1'b1;
    step();
    srst = 1'b0;
    req_async = 4'b0101;
    bus_async = {32'h0, 32'hA2, 32'h0, 32'hA0};
    m_ready   = 1'b0;
    step(); step(); step();
    chk_all("bp pend", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b1, 1'b0);
    step();
    chk_all("bp first", 1'b1, 32'hA0, 2'd0, 4'b0001, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all($sformatf("bp hold%0d", k), 1'b1, 32'hA0, 2'd0, 4'b0001, 1'b1, 1'b1);
    end
    m_ready = 1'b1;
    step();
    chk_all("bp second", 1'b1, 32'hA2, 2'd2, 4'b0101, 1'b1, 1'b1);
    req_async = '0;
    step();
    chk_all("bp drain", 1'b0, 32'h0, 2'd0, 4'b0101, 1'b1, 1'b0);
    step(); step();
    chk_all("bp idle", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b0, 1'b0);

    // Reset while ch0 is in ACKH and ch1 in PEND; ch1 keeps requesting.
    srst = 1'b1;
    step();
    srst = 1'b0;
    req_async = 4'b0011;
    bus_async = {32'h0, 32'h0, 32'hC1C1C1C1, 32'hC0C0C0C0};
    m_ready   = 1'b0;
    step(); step(); step(); step();
    chk_all("rst pre", 1'b1, 32'hC0C0C0C0, 2'd0, 4'b0001, 1'b1, 1'b1);
    srst = 1'b1;
    step();
    chk_all("rst mid", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b0, 1'b1);
    srst = 1'b0;
    req_async = 4'b0010;
    m_ready   = 1'b1;
    step();
    chk_all("rst e1", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("rst e2", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("rst e3", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b1, 1'b0);
    step();
    chk_all("rst redeliver", 1'b1, 32'hC1C1C1C1, 2'd1, 4'b0010, 1'b1, 1'b1);
    req_async = '0;
    step(); step(); step();
    chk_all("rst idle", 1'b0, 32'h0, 2'd0, 4'b0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_mchan_rx.md
# cdc_mchan_rx

Multi-channel receive side of the four-phase request/acknowledge bus crossing. Up to NUM_CHANNELS foreign-domain senders each present a request line and a data bus; this block synchronises every request into `aclk`, captures the data, returns a level acknowledge, and merges all channels onto a single valid/ready stream tagged with the channel index. It sits at the destination edge of the DRM controller's clock crossings and replaces per-channel bus crossings that have no back-pressure or arbitration.

## Interface
- NUM_CDC_STAGE, 2: synchroniser depth per request line; minimum 2.
- NUM_CHANNELS, 4: number of independent sender channels; minimum 1.
- BUS_WIDTH, 32: data width per channel.
- CHAN_W, derived: max(1, clog2(NUM_CHANNELS)); not overridable.
- aclk  in  1  sole clock; one clock.
- srst  in  1  reset; synchronous and active-high.
- req_async  in  NUM_CHANNELS  per-channel request from the foreign domain; unsynchronised.
- bus_async  in  NUM_CHANNELS*BUS_WIDTH  per-channel data; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH]. The sender holds it stable from before the request rises until it sees the acknowledge high.
- ack_async  out  NUM_CHANNELS  per-channel acknowledge level; driven directly from flops, with no combinational logic on the output.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  BUS_WIDTH  captured word.
- m_chan  out  CHAN_W  index of the channel that supplied m_data.
- busy  out  1  high while any channel is not in IDLE.

## Operation
- Per-channel synchroniser: NUM_CDC_STAGE flops; req_s is the last stage. The synchroniser flops carry ASYNC_REG.
- Per-channel FSM states:
  - IDLE: ack=0. On req_s=1, load bus_async slice into the hold register and go to PEND.
  - PEND: ack=0; channel is requesting the arbiter. On grant, go to ACKH.
  - ACKH: ack=1. On req_s=0, go to IDLE; ack falls on that transition.
- A new request on a channel is accepted only after that channel returns to IDLE. This makes overrun impossible by protocol.
- Output register (m_valid, m_data, m_chan) is free when m_valid=0 or when m_valid&m_ready.
- Arbiter runs only when the output register is free:
  - Round-robin over channels in PEND, searching from last_grant+1 with wrap-around.
  - At most one grant per cycle.
  - Granted channel's hold word and index load the output register and m_valid=1.
- last_grant updates only on a grant.
- m_valid stays high and m_data/m_chan stay stable until m_ready=1. A new word loads in the same cycle as the handshake, so throughput is one word per cycle across channels.
- Ack ordering: a channel's ack never rises before its word is in the output register.
- busy = OR over channels of (state != IDLE).

## Timing
- Reset (srst=1 at an edge) produces, at the next edge:
  - ack_async=0, m_valid=0, m_data=0, m_chan=0, busy=0.
  - Synchronisers=0, hold registers=0, last_grant=NUM_CHANNELS-1 (so channel 0 has first priority), every FSM in IDLE.
- Latency, output free and no contention:
  - req_async sampled high at edge 1.
  - req_s high after edge NUM_CDC_STAGE.
  - Capture and PEND at edge NUM_CDC_STAGE+1.
  - m_valid=1 and ack=1 at edge NUM_CDC_STAGE+2.
- Ack release: ack falls NUM_CDC_STAGE+1 edges after req_async is first sampled low.
- Simultaneous PEND on several channels: granted on consecutive free cycles in round-robin order. Non-granted channels hold ack=0.
- Back-pressure (m_ready=0): no grants and no new acks; PEND channels wait indefinitely.
- Reset mid-transfer: everything returns to reset values.
  - A sender still holding req high is seen as a fresh request and delivered again.
  - Delivery is therefore at-least-once across reset; consumers tolerate duplicates.
- NUM_CHANNELS=1: the arbiter degenerates to always-grant and m_chan is constant 0.

## Structure
- Shared package cdc_pkg:
  - chan_state_t enum {IDLE, PEND, ACKH}.
  - clog2-based CHAN_W helper function.
- Sub-module cdc_mchan_rx_chan: synchroniser, FSM, hold register and ack flop for one channel. The top instantiates NUM_CHANNELS copies in a generate loop and owns the arbiter and output register.
- Capture of bus_async is a multicycle path, valid by protocol (stable ≥ NUM_CDC_STAGE cycles before req_s). Constrain it with a max-delay exception, not a false path.

## Test plan
- Single transfer, ch1 req high with data 0xDEADBEEF, m_ready=1 -> m_valid pulse at edge NUM_CDC_STAGE+2 with m_data=0xDEADBEEF, m_chan=1, ack_async[1] rising the same cycle; req low -> ack low NUM_CDC_STAGE+1 edges later, busy=0.
- All 4 channels request in the same cycle, data 0x10..0x13, m_ready=1 -> four consecutive beats, m_chan 0,1,2,3, data matching.
- Round-robin wrap, ch2 granted last, then ch1 and ch3 pending -> order is 3 then 1.
- Back-pressure: m_ready=0 for 10 cycles with ch0 and ch2 pending -> m_data stable, only the granted channel's ack high, the other ack low; m_ready=1 -> second beat the next cycle.
- srst pulsed while ch0 in ACKH and ch1 in PEND -> all outputs 0 next edge; ch1 req still high -> ch1 word delivered again after NUM_CDC_STAGE+2 edges.
- Sender changes bus_async immediately after seeing ack high -> delivered word equals the pre-ack value.
